// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Memory-side responder for a core load/store port. It accepts one
//   word-aligned request at a time through a valid/ready handshake. After a
//   fixed access latency it returns read data, or a write acknowledge, as a
//   one-cycle response pulse. The backing store is a word-addressed RAM
//   mapped at byte address BASE.
//
// Parameters
//   ADDR_BITS  log2 of RAM depth in 32-bit words
//   LATENCY    accept-to-response latency (1..15)
//   BASE       byte address of word 0
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   req_valid/ready     request handshake; ready only in IDLE
//   req_write           1 = store word, 0 = load word
//   req_addr            byte address
//   req_wdata           store data
//   resp_valid          one-cycle response pulse
//   resp_rdata          load data; 0 for stores and errored requests
//   resp_err            misaligned or out-of-window request
module data_memory_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE      = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned WORDS = 1 << ADDR_BITS;
  // 33-bit window bounds so BASE + size cannot wrap.
  localparam logic [32:0] WIN_LO = {1'b0, BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_BITS);
  // WAIT lasts LATENCY-1 cycles; the counter starts at 0 on acceptance.
  localparam logic [3:0]  WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rerr_q, rerr_d;

  logic [31:0]            mem [WORDS];

  logic                   in_err;
  logic [ADDR_BITS-1:0]   in_idx;
  logic                   cur_wr, cur_err;
  logic [ADDR_BITS-1:0]   cur_idx;
  logic [31:0]            cur_wdata;
  logic [31:0]            rd_word;
  logic                   accept, enter_resp, commit;

  assign in_err = (req_addr[1:0] != 2'b00)
               || ({1'b0, req_addr} <  WIN_LO)
               || ({1'b0, req_addr} >= WIN_HI);
  assign in_idx = ADDR_BITS'((req_addr - BASE) >> 2);

  assign accept = (state_q == IDLE) && req_valid;

  // With LATENCY=1 the accept edge is also the RESP entry edge, so the
  // request fields come straight from the inputs rather than the latch.
  assign cur_wr    = (state_q == IDLE) ? req_write : wr_q;
  assign cur_err   = (state_q == IDLE) ? in_err    : err_q;
  assign cur_idx   = (state_q == IDLE) ? in_idx    : idx_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign enter_resp = (state_q == IDLE) ? (req_valid && (LATENCY == 1))
                                        : ((state_q == WAIT) && (cnt_q == WAIT_LAST));
  assign commit  = enter_resp && cur_wr && !cur_err;
  assign rd_word = mem[cur_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) state_d = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) state_d = RESP;
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d    = wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    if (accept) begin
      wr_d    = req_write;
      err_d   = in_err;
      idx_d   = in_idx;
      wdata_d = req_wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    if (enter_resp) begin
      rdata_d = (!cur_wr && !cur_err) ? rd_word : '0;
      rerr_d  = cur_err;
    end else if (state_q == RESP) begin
      rdata_d = '0;
      rerr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // RAM is not reset; the reset term blocks a commit while reset is held.
  always_ff @(posedge clk) begin
    if (commit && reset) mem[cur_idx] <= cur_wdata;
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule
